counter_run_sequencer: RTL and testbench
========================================

Name: counter_run_sequencer

Overview:
- Control block for the 8-bit up/down LED counter datapath. Accepts raw push-buttons and a bounce-mode switch, and generates a one-cycle count-enable tick from a prescaler.
- Sequences run, pause and direction. In bounce mode it auto-reverses direction at the count limits, using the counter value fed back from the datapath.
- Sits between the board I/O and the counter; drives the counter's enable and `dir` inputs.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per count tick (100 MHz clock gives 0.1 s); must be >= 2.
- DEB_CYCLES, 1_000_000, stable cycles required to accept a button level (10 ms).
- CNT_W, 8, width of the counter value.
- UP_LIMIT, 8'hFF, upper reversal point in bounce mode.
- DOWN_LIMIT, 8'h00, lower reversal point in bounce mode.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_start  input  1  raw async start/pause button, active-high.
- btn_dir  input  1  raw async direction-toggle button, active-high.
- bounce_en  input  1  raw async slide switch; 1 enables auto-reverse at the limits.
- count_in  input  CNT_W  current counter value from the datapath.
- tick  output  1  one-cycle count enable to the datapath.
- dir  output  1  count direction to the datapath; 1 = up, 0 = down.
- running  output  1  high in RUN_UP and RUN_DOWN.
- state_o  output  2  FSM state: 00 IDLE, 01 RUN_UP, 10 RUN_DOWN, 11 PAUSED.

Behaviour:
- Reset values (asynchronous while rst_n=0): tick=0, dir=1, running=0, state_o=00. Prescaler, debounce counters and synchronizers are all cleared.
- Input conditioning:
  - Each of btn_start, btn_dir and bounce_en passes through a 2-FF synchronizer.
  - Buttons are then debounced: the accepted level changes only after DEB_CYCLES consecutive equal synchronized samples.
  - A rising edge of an accepted button level produces a one-cycle internal press pulse. Release produces nothing.
  - Button press latency from a stable raw input is DEB_CYCLES+3 cycles.
  - bounce_en is synchronized only, not debounced.
- FSM transitions on a start press:
  - IDLE -> RUN_UP.
  - RUN_UP or RUN_DOWN -> PAUSED; the run direction is held in dir.
  - PAUSED -> RUN_UP if dir=1, RUN_DOWN if dir=0.
- Leaving IDLE happens only via a start press; IDLE is re-entered only via reset.
- Dir press:
  - Ignored in IDLE.
  - In RUN_*: swaps RUN_UP and RUN_DOWN and toggles dir on the same edge.
  - In PAUSED: toggles dir, state unchanged.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN_*.
  - Holds its value in PAUSED; cleared in IDLE.
  - Not cleared on a direction change.
- Tick:
  - Registered; high for exactly one cycle, in the cycle after the prescaler reaches TICK_DIV-1, i.e. one tick per TICK_DIV running cycles.
  - The first tick after IDLE -> RUN_UP occurs TICK_DIV cycles after the state change.
  - Never high outside RUN_*.
- Bounce mode, evaluated on the prescaler terminal edge (the same edge that raises tick):
  - If bounce_en=1, state RUN_UP and count_in==UP_LIMIT: go to RUN_DOWN and set dir=0 on that edge, so the datapath sees dir=0 together with tick.
  - If bounce_en=1, state RUN_DOWN and count_in==DOWN_LIMIT: go to RUN_UP and set dir=1.
- With bounce_en=0 no reversal occurs; the datapath wraps naturally (FF -> 00 up, 00 -> FF down).
- Simultaneous events:
  - Start press together with dir press: start is applied first, then dir if the resulting state is RUN_* or PAUSED. Examples: RUN_UP -> PAUSED with dir=0; IDLE -> RUN_UP with the dir press dropped.
  - Dir press together with a bounce reversal: only the bounce reversal applies; the dir press is discarded.
  - Start press on the prescaler terminal edge: the pause wins and no tick is issued; the prescaler holds at TICK_DIV-1. On resume, tick fires on the first resumed edge.
- Reset mid-run: all outputs return to reset values immediately (asynchronous); tick is never left high.
- running = (state_o==01 || state_o==10), decoded from the registered state with no extra latency.

Test Plan:
Benches use TICK_DIV=4 and DEB_CYCLES=3.
- Reset and start: hold rst_n=0 for 5 cycles -> tick=0, dir=1, state_o=00. Release, then press start for 10 cycles -> state_o=01 after 6 cycles; tick pulses every 4 cycles; dir stays 1.
- Debounce: toggle btn_start every cycle for 20 cycles, then leave it low -> no state change. A 2-cycle glitch -> ignored.
- Pause and resume: run to 2 cycles after a tick, press start -> PAUSED, no tick, prescaler frozen. Press again -> RUN_UP, next tick 2 cycles after resume.
- Direction toggle: in RUN_UP press dir -> state_o=10 and dir=0 on the same edge. In IDLE press dir -> no change, dir=1.
- Bounce up: bounce_en=1, count_in=FF, RUN_UP -> at the next terminal edge tick=1, dir=0 and state_o=10 in the same cycle. With bounce_en=0, same stimulus -> dir stays 1.
- Bounce down and collision: RUN_DOWN, count_in=00, dir press landing on the terminal edge -> RUN_UP, dir=1 (single toggle). Assert rst_n=0 during a tick -> tick drops immediately, state_o=00.

Source files
------------

// File: rtl/counter_run_sequencer.sv
// counter_run_sequencer
//   Control block for the 8-bit up/down LED counter. Conditions the raw board
//   inputs, sequences run/pause/direction, and generates the count-enable tick.
//
// Parameters
//   TICK_DIV    clk cycles per count tick (>= 2)
//   DEB_CYCLES  consecutive equal synchronized samples needed to accept a button level
//   CNT_W       counter value width
//   UP_LIMIT    upper reversal point in bounce mode
//   DOWN_LIMIT  lower reversal point in bounce mode
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_start  raw start/pause button, active-high
//   btn_dir    raw direction-toggle button, active-high
//   bounce_en  raw slide switch, 1 = auto-reverse at the limits
//   count_in   current counter value from the datapath
//   tick       one-cycle count enable to the datapath
//   dir        count direction, 1 = up, 0 = down
//   running    high in RUN_UP and RUN_DOWN
//   state_o    00 IDLE, 01 RUN_UP, 10 RUN_DOWN, 11 PAUSED
module counter_run_sequencer #(
    parameter int unsigned      TICK_DIV   = 10_000_000,
    parameter int unsigned      DEB_CYCLES = 1_000_000,
    parameter int unsigned      CNT_W      = 8,
    parameter logic [CNT_W-1:0] UP_LIMIT   = {CNT_W{1'b1}},
    parameter logic [CNT_W-1:0] DOWN_LIMIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_start,
    input  logic             btn_dir,
    input  logic             bounce_en,
    input  logic [CNT_W-1:0] count_in,
    output logic             tick,
    output logic             dir,
    output logic             running,
    output logic [1:0]       state_o
);

    localparam int unsigned     PreW   = $clog2(TICK_DIV);
    localparam int unsigned     DebW   = $clog2(DEB_CYCLES + 1);
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

    // Bit positions in the synchronizer vector.
    localparam int unsigned BitStart  = 0;
    localparam int unsigned BitDir    = 1;
    localparam int unsigned BitBounce = 2;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRunUp   = 2'b01,
        StRunDown = 2'b10,
        StPaused  = 2'b11
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers: {bounce_en, btn_dir, btn_start}
    // ------------------------------------------------------------------
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bounce_en, btn_dir, btn_start};
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce: the accepted level follows the synchronized input
    // only after DEB_CYCLES consecutive samples that differ from it.
    // ------------------------------------------------------------------
    logic [1:0]      level_q;
    logic [1:0]      level_prev_q;
    logic [DebW-1:0] deb_cnt_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q      <= '0;
            level_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            level_prev_q <= level_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebMax) begin
                    level_q[i]   <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    // One-cycle press pulses on the rising edge of the accepted level.
    logic [1:0] press;
    logic       start_press;
    logic       dir_press;
    logic       bounce_sync;

    assign press       = level_q & ~level_prev_q;
    assign start_press = press[BitStart];
    assign dir_press   = press[BitDir];
    assign bounce_sync = sync2_q[BitBounce];

    // ------------------------------------------------------------------
    // Sequencer FSM with prescaler, registered tick and direction.
    // ------------------------------------------------------------------
    state_e          state_q;
    logic            dir_q;
    logic            tick_q;
    logic [PreW-1:0] pre_q;
    logic            bounce_hit;

    // Reversal condition; only acted on at the prescaler terminal edge.
    assign bounce_hit = bounce_sync &&
                        (((state_q == StRunUp)   && (count_in == UP_LIMIT)) ||
                         ((state_q == StRunDown) && (count_in == DOWN_LIMIT)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dir_q   <= 1'b1;
            tick_q  <= 1'b0;
            pre_q   <= '0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    pre_q <= '0;
                    // A dir press arriving with the start press is dropped here.
                    if (start_press) begin
                        state_q <= StRunUp;
                        dir_q   <= 1'b1;
                    end
                end

                StPaused: begin
                    // Prescaler holds; start resumes in the (possibly toggled) direction.
                    if (start_press) begin
                        state_q <= (dir_q ^ dir_press) ? StRunUp : StRunDown;
                        dir_q   <= dir_q ^ dir_press;
                    end else if (dir_press) begin
                        dir_q <= ~dir_q;
                    end
                end

                StRunUp, StRunDown: begin
                    if (start_press) begin
                        // Pause wins over a terminal edge: no tick, prescaler holds.
                        state_q <= StPaused;
                        dir_q   <= dir_q ^ dir_press;
                    end else begin
                        if (pre_q == PreMax) begin
                            tick_q <= 1'b1;
                            pre_q  <= '0;
                        end else begin
                            pre_q <= pre_q + PreW'(1);
                        end

                        // A bounce reversal swallows a coincident dir press.
                        if ((pre_q == PreMax && bounce_hit) || dir_press) begin
                            state_q <= (state_q == StRunUp) ? StRunDown : StRunUp;
                            dir_q   <= ~dir_q;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tick    = tick_q;
    assign dir     = dir_q;
    assign state_o = state_q;
    assign running = (state_q == StRunUp) || (state_q == StRunDown);

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Directed self-checking bench for counter_run_sequencer with TICK_DIV=4, DEB_CYCLES=3.
// A button press takes effect on the 6th rising edge after the raw input goes high.
module tb_counter_run_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn_start;
    logic       btn_dir;
    logic       bounce_en;
    logic [7:0] count_in;
    logic       tick;
    logic       dir;
    logic       running;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    counter_run_sequencer #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3),
        .CNT_W      (8),
        .UP_LIMIT   (8'hFF),
        .DOWN_LIMIT (8'h00)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_dir   (btn_dir),
        .bounce_en (bounce_en),
        .count_in  (count_in),
        .tick      (tick),
        .dir       (dir),
        .running   (running),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; sample/drive 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the selected buttons for 4 cycles, then release.
    task automatic pulse(input logic s, input logic d);
        btn_start = s;
        btn_dir   = d;
        cyc(4);
        btn_start = 1'b0;
        btn_dir   = 1'b0;
    endtask

    // Step until tick is seen (checks the current sample first), bounded.
    task automatic wait_tick(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < max_cyc) begin
            cyc(1);
            n++;
        end
        check_eq(tag, {31'd0, tick}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nticks;
        rst_n     = 1'b0;
        btn_start = 1'b0;
        btn_dir   = 1'b0;
        bounce_en = 1'b0;
        count_in  = 8'h55;

        // Reset values
        cyc(5);
        check_eq("rst_tick", {31'd0, tick}, 32'd0);
        check_eq("rst_dir", {31'd0, dir}, 32'd1);
        check_eq("rst_state", {30'd0, state_o}, 32'd0);
        check_eq("rst_running", {31'd0, running}, 32'd0);

        // Start held 10 cycles: RUN_UP on edge 6, ticks on edges 10 and 14
        rst_n     = 1'b1;
        btn_start = 1'b1;
        cyc(5);
        check_eq("start_lat_e5", {30'd0, state_o}, 32'd0);
        cyc(1);
        check_eq("start_lat_e6", {30'd0, state_o}, 32'd1);
        check_eq("start_running", {31'd0, running}, 32'd1);
        cyc(3);
        check_eq("tick_e9", {31'd0, tick}, 32'd0);
        cyc(1);
        btn_start = 1'b0;
        check_eq("tick_e10", {31'd0, tick}, 32'd1);
        check_eq("dir_e10", {31'd0, dir}, 32'd1);
        cyc(1);
        check_eq("tick_e11", {31'd0, tick}, 32'd0);
        cyc(3);
        check_eq("tick_e14", {31'd0, tick}, 32'd1);

        // Debounce: fast toggling and a 2-cycle glitch are ignored
        cyc(4);
        for (int i = 0; i < 20; i++) begin
            btn_start = ~btn_start;
            cyc(1);
        end
        btn_start = 1'b0;
        cyc(6);
        check_eq("deb_toggle", {30'd0, state_o}, 32'd1);
        btn_start = 1'b1;
        cyc(2);
        btn_start = 1'b0;
        cyc(8);
        check_eq("deb_glitch", {30'd0, state_o}, 32'd1);

        // Pause with prescaler at 2, resume: tick 2 cycles after resume
        wait_tick("pause_sync", 8);
        cyc(1);
        pulse(1'b1, 1'b0);
        cyc(1);
        check_eq("pause_pre", {30'd0, state_o}, 32'd1);
        cyc(1);
        check_eq("pause_state", {30'd0, state_o}, 32'd3);
        check_eq("pause_running", {31'd0, running}, 32'd0);
        nticks = 0;
        for (int i = 0; i < 8; i++) begin
            if (tick) nticks++;
            cyc(1);
        end
        check_eq("pause_no_tick", nticks, 32'd0);
        pulse(1'b1, 1'b0);
        cyc(1);
        check_eq("resume_pre", {30'd0, state_o}, 32'd3);
        cyc(1);
        check_eq("resume_state", {30'd0, state_o}, 32'd1);
        check_eq("resume_tick0", {31'd0, tick}, 32'd0);
        cyc(1);
        check_eq("resume_tick1", {31'd0, tick}, 32'd0);
        cyc(1);
        check_eq("resume_tick2", {31'd0, tick}, 32'd1);

        // Direction toggle in RUN_UP
        cyc(6);
        pulse(1'b0, 1'b1);
        cyc(1);
        check_eq("dirtog_pre", {30'd0, state_o}, 32'd1);
        cyc(1);
        check_eq("dirtog_state", {30'd0, state_o}, 32'd2);
        check_eq("dirtog_dir", {31'd0, dir}, 32'd0);

        // Bounce up: RUN_UP at FF reverses on the tick edge
        count_in  = 8'hFF;
        bounce_en = 1'b1;
        cyc(6);
        pulse(1'b0, 1'b1);
        cyc(2);
        check_eq("bup_setup", {30'd0, state_o}, 32'd1);
        cyc(1);
        wait_tick("bup_tick", 8);
        check_eq("bup_dir", {31'd0, dir}, 32'd0);
        check_eq("bup_state", {30'd0, state_o}, 32'd2);

        // Same with bounce disabled: no reversal
        bounce_en = 1'b0;
        cyc(6);
        pulse(1'b0, 1'b1);
        cyc(2);
        check_eq("nob_setup", {30'd0, state_o}, 32'd1);
        cyc(1);
        wait_tick("nob_tick", 8);
        check_eq("nob_dir", {31'd0, dir}, 32'd1);
        check_eq("nob_state", {30'd0, state_o}, 32'd1);

        // Bounce down colliding with a dir press on the terminal edge
        count_in = 8'h00;
        cyc(6);
        pulse(1'b0, 1'b1);
        cyc(2);
        check_eq("bdn_setup", {30'd0, state_o}, 32'd2);
        cyc(6);
        wait_tick("bdn_sync", 8);
        cyc(2);
        btn_dir = 1'b1;
        cyc(3);
        bounce_en = 1'b1;
        cyc(1);
        btn_dir = 1'b0;
        cyc(1);
        check_eq("coll_pre_state", {30'd0, state_o}, 32'd2);
        cyc(1);
        check_eq("coll_tick", {31'd0, tick}, 32'd1);
        check_eq("coll_state", {30'd0, state_o}, 32'd1);
        check_eq("coll_dir", {31'd0, dir}, 32'd1);

        // Asynchronous reset in the middle of a tick
        cyc(1);
        wait_tick("rst_sync", 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("amid_tick", {31'd0, tick}, 32'd0);
        check_eq("amid_state", {30'd0, state_o}, 32'd0);
        check_eq("amid_dir", {31'd0, dir}, 32'd1);
        bounce_en = 1'b0;
        count_in  = 8'h55;
        cyc(2);
        rst_n = 1'b1;

        // Dir press in IDLE is ignored
        cyc(2);
        pulse(1'b0, 1'b1);
        cyc(4);
        check_eq("idle_dir_state", {30'd0, state_o}, 32'd0);
        check_eq("idle_dir_dir", {31'd0, dir}, 32'd1);

        // Simultaneous start+dir: from IDLE dir dropped, from RUN_UP pause with dir=0
        cyc(2);
        pulse(1'b1, 1'b1);
        cyc(2);
        check_eq("sim_idle_state", {30'd0, state_o}, 32'd1);
        check_eq("sim_idle_dir", {31'd0, dir}, 32'd1);
        cyc(6);
        pulse(1'b1, 1'b1);
        cyc(2);
        check_eq("sim_run_state", {30'd0, state_o}, 32'd3);
        check_eq("sim_run_dir", {31'd0, dir}, 32'd0);
        cyc(6);
        pulse(1'b1, 1'b0);
        cyc(2);
        check_eq("resume_down", {30'd0, state_o}, 32'd2);

        // Start press on the terminal edge: pause, no tick; tick on first resumed edge
        wait_tick("term_sync", 8);
        cyc(2);
        pulse(1'b1, 1'b0);
        cyc(1);
        check_eq("term_pre_state", {30'd0, state_o}, 32'd2);
        cyc(1);
        check_eq("term_state", {30'd0, state_o}, 32'd3);
        check_eq("term_tick", {31'd0, tick}, 32'd0);
        cyc(6);
        pulse(1'b1, 1'b0);
        cyc(2);
        check_eq("term_resume_state", {30'd0, state_o}, 32'd2);
        check_eq("term_resume_tick0", {31'd0, tick}, 32'd0);
        cyc(1);
        check_eq("term_resume_tick1", {31'd0, tick}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
